alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 217 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Single-issue ALU with an optional iterative multiply/divide unit (one bit per cycle).
// Define ALU_MULDIV_M_EXT_EN to build opcodes 16-23; otherwise they decode as illegal.
module alu_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic [4:0]       operation,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             illegal
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             alu_legal;
   logic             md_sel;
   logic             md_last;
   logic [WIDTH-1:0] md_res;
   logic [WIDTH-1:0] alu_res;
   logic [SW-1:0]    shamt;
   logic             load_res;
   logic [WIDTH-1:0] res_nxt;
   logic             ill_nxt;

   assign accept    = (state == IDLE) && in_valid;
   assign shamt     = operand2[SW-1:0];
   assign alu_legal = (operation <= 5'd11);

   // Single-cycle operations, evaluated straight from the request inputs
   always_comb begin
      alu_res = '0;
      case (operation)
         5'd0:    alu_res = operand1 + operand2;
         5'd1:    alu_res = operand1 - operand2;
         5'd2:    alu_res = operand1 & operand2;
         5'd3:    alu_res = operand1 | operand2;
         5'd4:    alu_res = operand1 << shamt;
         5'd5:    alu_res = operand1 >> shamt;
         5'd6:    alu_res = operand1 ^ operand2;
         5'd7:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
         5'd8:    alu_res = operand2 + WIDTH'(4);
         5'd9:    alu_res = operand2;
         5'd10:   alu_res = WIDTH'($signed(operand1) >>> shamt);
         5'd11:   alu_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_MULDIV_M_EXT_EN
   logic             md_start;
   logic [WIDTH:0]   md_hi;
   logic [WIDTH-1:0] md_lo;
   logic [WIDTH-1:0] md_b;
   logic [WIDTH-1:0] md_a;
   logic [2:0]       md_op;
   logic             md_neg;
   logic             md_negr;
   logic             md_dz;
   logic [CW-1:0]    md_cnt;

   logic             a_sgn;
   logic             b_sgn;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH:0]   hi_step;
   logic [WIDTH-1:0] lo_step;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   assign md_sel   = (operation[4:3] == 2'b10);
   assign md_start = accept && md_sel;
   assign md_last  = (state == BUSY) && (md_cnt == CW'(WIDTH - 1));

   // Both units work on magnitudes; signs are reapplied when the result is formed
   always_comb begin
      if (operation[2]) begin
         a_sgn = ~operation[0];
         b_sgn = ~operation[0];
      end else begin
         a_sgn = (operation[1:0] != 2'b11);
         b_sgn = ~operation[1];
      end
      a_neg = a_sgn && operand1[WIDTH-1];
      b_neg = b_sgn && operand2[WIDTH-1];
      mag_a = a_neg ? -operand1 : operand1;
      mag_b = b_neg ? -operand2 : operand2;
   end

   // One shift-add (multiply) or restoring-subtract (divide) step
   always_comb begin
      mul_sum   = md_hi + (md_lo[0] ? {1'b0, md_b} : '0);
      div_shift = {md_hi[WIDTH-1:0], md_lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, md_b});
      if (md_op[2]) begin
         hi_step = div_ge ? (div_shift - {1'b0, md_b}) : div_shift;
         lo_step = {md_lo[WIDTH-2:0], div_ge};
      end else begin
         hi_step = {1'b0, mul_sum[WIDTH:1]};
         lo_step = {mul_sum[0], md_lo[WIDTH-1:1]};
      end
   end

   // Result formed from the final step so it lands in the same cycle as DONE
   always_comb begin
      prod   = {hi_step[WIDTH-1:0], lo_step};
      prod_s = md_neg ? -prod : prod;
      quo    = md_neg ? -lo_step : lo_step;
      rem    = md_negr ? -hi_step[WIDTH-1:0] : hi_step[WIDTH-1:0];
      if (md_dz) begin
         quo = '1;
         rem = md_a;
      end
      if (md_op[2]) begin
         md_res = md_op[1] ? rem : quo;
      end else begin
         md_res = (md_op[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (md_start) begin
         md_hi   <= '0;
         md_lo   <= mag_a;
         md_b    <= mag_b;
         md_a    <= operand1;
         md_op   <= operation[2:0];
         md_neg  <= a_neg ^ b_neg;
         md_negr <= a_neg;
         md_dz   <= (operand2 == '0);
         md_cnt  <= '0;
      end else if (state == BUSY) begin
         md_hi  <= hi_step;
         md_lo  <= lo_step;
         md_cnt <= md_cnt + CW'(1);
      end
   end
`else
   assign md_sel  = 1'b0;
   assign md_last = 1'b0;
   assign md_res  = '0;
`endif

   always_comb begin
      state_nxt = state;
      load_res  = 1'b0;
      res_nxt   = alu_res;
      ill_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (md_sel) begin
                  state_nxt = BUSY;
               end else begin
                  state_nxt = DONE;
                  load_res  = 1'b1;
                  res_nxt   = alu_legal ? alu_res : '0;
                  ill_nxt   = ~alu_legal;
               end
            end
         end
         BUSY: begin
            if (md_last) begin
               state_nxt = DONE;
               load_res  = 1'b1;
               res_nxt   = md_res;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake flags are registered copies of the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         illegal   <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         if (load_res) begin
            result  <= res_nxt;
            illegal <= ill_nxt;
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed and randomized bench for alu_muldiv (WIDTH=32) against an arithmetic reference model.
module tb_alu_muldiv;

   localparam int unsigned W = 32;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] operand1;
   logic [W-1:0] operand2;
   logic [4:0]   operation;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         illegal;

   int checks = 0;
   int errors = 0;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .operand1(operand1),
      .operand2(operand2),
      .operation(operation),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the operation definitions
   function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic ill, output int lat);
      longint     sa;
      longint     sb;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      r   = '0;
      ill = 1'b0;
      lat = 1;
      p   = '0;
      case (op)
         5'd0:  r = a + b;
         5'd1:  r = a - b;
         5'd2:  r = a & b;
         5'd3:  r = a | b;
         5'd4:  r = a << b[4:0];
         5'd5:  r = a >> b[4:0];
         5'd6:  r = a ^ b;
         5'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
         5'd8:  r = b + 32'd4;
         5'd9:  r = b;
         5'd10: r = 32'($signed(a) >>> b[4:0]);
         5'd11: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_M_EXT_EN
         5'd16: begin p = 64'(sa * sb); r = p[31:0]; lat = 33; end
         5'd17: begin p = 64'(sa * sb); r = p[63:32]; lat = 33; end
         5'd18: begin p = 64'(sa * longint'({32'h0, b})); r = p[63:32]; lat = 33; end
         5'd19: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; lat = 33; end
         5'd20: begin r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb); lat = 33; end
         5'd21: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = 33; end
         5'd22: begin r = (b == 0) ? a : 32'(sa % sb); lat = 33; end
         5'd23: begin r = (b == 0) ? a : a % b; lat = 33; end
`endif
         default: begin r = '0; ill = 1'b1; end
      endcase
   endfunction

   // One full transaction: accept, measure latency, check, then drain
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, output logic [31:0] got);
      logic [31:0] er;
      logic        ei;
      int          el;
      int          lat;
      ref_model(op, a, b, er, ei, el);
      chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      operation = op;
      operand1  = a;
      operand2  = b;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      got = result;
      chk({tag, ".latency"}, 64'(lat), 64'(el));
      chk({tag, ".result"}, 64'(result), 64'(er));
      chk({tag, ".illegal"}, 64'(illegal), 64'(ei));
      chk({tag, ".busy_ready"}, 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".drained"}, 64'({out_valid, in_ready}), 64'b01);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] got;
      int          seen;
      clk       = 1'b0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      operand1  = '0;
      operand2  = '0;
      operation = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.out_valid", 64'(out_valid), 64'd0);
      chk("reset.result", 64'(result), 64'd0);
      chk("reset.illegal", 64'(illegal), 64'd0);
      chk("reset.in_ready", 64'(in_ready), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(5'd0, 32'h7FFF_FFFF, 32'h1, "add_wrap", got);
      chk("add_wrap.const", 64'(got), 64'h8000_0000);
      run_op(5'd10, 32'h8000_0000, 32'h24, "sra", got);
      chk("sra.const", 64'(got), 64'hF800_0000);
      run_op(5'd8, 32'hFFFF_FFFE, 32'hFFFF_FFFE, "jal_wrap", got);
      run_op(5'd7, 32'hFFFF_FFFF, 32'h1, "slt", got);
      run_op(5'd11, 32'hFFFF_FFFF, 32'h1, "sltu", got);
      run_op(5'd4, 32'h1, 32'hFFFF_FFE1, "sll_mask", got);

      run_op(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh", got);
      run_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", got);
`ifdef ALU_MULDIV_M_EXT_EN
      chk("mulhu.const", 64'(got), 64'hFFFF_FFFE);
`endif
      run_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", got);
`ifdef ALU_MULDIV_M_EXT_EN
      chk("div_ovf.const", 64'(got), 64'h8000_0000);
`endif
      run_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", got);
      run_op(5'd21, 32'd7, 32'd0, "divu_z", got);
      run_op(5'd23, 32'd7, 32'd0, "remu_z", got);
`ifdef ALU_MULDIV_M_EXT_EN
      chk("remu_z.const", 64'(got), 64'd7);
`endif
      run_op(5'd22, 32'hFFFF_FFF9, 32'd2, "rem_neg", got);
`ifdef ALU_MULDIV_M_EXT_EN
      chk("rem_neg.const", 64'(got), 64'hFFFF_FFFF);
`endif
      run_op(5'd31, 32'h1234, 32'h5678, "ill31", got);
      run_op(5'd16, 32'd6, 32'd7, "op16", got);
      run_op(5'd13, 32'd6, 32'd7, "ill13", got);

      // Output stall: result must hold and new requests must be ignored
      operation = 5'd0;
      operand1  = 32'd3;
      operand2  = 32'd4;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall.state", 64'({out_valid, in_ready, illegal}), 64'b100);
         chk("stall.result", 64'(result), 64'd7);
         in_valid = (i % 2 == 0);
         operand1 = $urandom;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("stall.result_end", 64'(result), 64'd7);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("stall.drained", 64'({out_valid, in_ready}), 64'b01);
      @(posedge clk); #1;
      chk("stall.no_extra", 64'(out_valid), 64'd0);

      // Reset mid-operation abandons it
      operation = 5'd20;
      operand1  = 32'd100;
      operand2  = 32'd7;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_busy.state", 64'({out_valid, in_ready}), 64'b01);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      chk("rst_busy.no_result", 64'(seen), 64'd0);

      // Reset wins over a simultaneous accept
      operation = 5'd0;
      in_valid  = 1'b1;
      reset     = 1'b1;
      @(posedge clk); #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("rst_accept.state", 64'({out_valid, in_ready}), 64'b01);
      @(posedge clk); #1;
      chk("rst_accept.no_result", 64'(out_valid), 64'd0);

      for (int n = 0; n < 150; n++) begin
         run_op(5'($urandom_range(0, 31)), pick(), pick(), $sformatf("rand%0d", n), got);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
